// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI byte command decoder, register bank and LED driver; define SPI_REG_BANK_ERR_CNT_EN for an RO error-frame counter at address 4
module spi_reg_bank #(
  parameter int ADDR_W = 4,
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int PRESCALE_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cs_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_led,
  output logic       o_led_en
);
`ifdef SPI_REG_BANK_ERR_CNT_EN
  localparam int FIRST_SCRATCH = 5;
`else
  localparam int FIRST_SCRATCH = 4;
`endif
  localparam int NREG = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE, CMD, WR, RD, ERR} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr, rd_addr;
  logic [7:0] ctrl, blink_div, frame_cnt, rd_data;
  logic [7:0] scratch [NREG];
  logic cmd_bad, wr_ok;
  logic [PRESCALE_W-1:0] presc;
  logic [7:0] div;
  logic blink_q;
`ifdef SPI_REG_BANK_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  assign o_led_en = 1'b1;
  assign o_busy = state != IDLE;
  assign cmd_bad = (i_rx_data[6:0] >> ADDR_W) != '0;
  assign rd_addr = (state == CMD) ? i_rx_data[ADDR_W-1:0] : ptr + 1'b1;
  assign wr_ok = ptr == ADDR_W'(1) || ptr == ADDR_W'(2) || ptr >= ADDR_W'(FIRST_SCRATCH);
  assign rd_data = (rd_addr == ADDR_W'(0)) ? ID_VALUE :
                   (rd_addr == ADDR_W'(1)) ? ctrl :
                   (rd_addr == ADDR_W'(2)) ? blink_div :
                   (rd_addr == ADDR_W'(3)) ? frame_cnt :
`ifdef SPI_REG_BANK_ERR_CNT_EN
                   (rd_addr == ADDR_W'(4)) ? err_cnt :
`endif
                   scratch[rd_addr];
  // command FSM: processes the byte first, then a CS rise ends the frame in the same cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      ptr <= '0;
      o_tx_data <= ID_VALUE;
      ctrl <= 8'h00;
      blink_div <= 8'hFF;
      frame_cnt <= 8'h00;
      for (int i = 0; i < NREG; i++) scratch[i] <= 8'h00;
`ifdef SPI_REG_BANK_ERR_CNT_EN
      err_cnt <= 8'h00;
`endif
    end else begin
      if (i_rx_valid) begin
        case (state)
          CMD: begin
            if (cmd_bad) begin
              state <= ERR;
              o_tx_data <= 8'hEE;
`ifdef SPI_REG_BANK_ERR_CNT_EN
              err_cnt <= err_cnt + {7'd0, ~&err_cnt};
`endif
            end else begin
              ptr <= i_rx_data[ADDR_W-1:0];
              state <= i_rx_data[7] ? WR : RD;
              o_tx_data <= i_rx_data[7] ? 8'h00 : rd_data;
            end
          end
          WR: begin
            if (wr_ok) begin
              if (ptr == ADDR_W'(1)) ctrl <= i_rx_data;
              else if (ptr == ADDR_W'(2)) blink_div <= i_rx_data;
              else scratch[ptr] <= i_rx_data;
            end
            ptr <= ptr + 1'b1;
            o_tx_data <= 8'h00;
          end
          RD: begin
            ptr <= ptr + 1'b1;
            o_tx_data <= rd_data;
          end
          default: ;
        endcase
      end
      if (state == IDLE) begin
        if (!i_cs_n) state <= CMD;
      end else if (i_cs_n) begin
        state <= IDLE;
        o_tx_data <= ID_VALUE;
        if (state != CMD || i_rx_valid) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
  // blink: free-running prescaler ticks a reloadable divider; blink off holds divider at reload
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc <= '0;
      div <= 8'h00;
      blink_q <= 1'b0;
      o_led <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      if (!ctrl[1]) begin
        blink_q <= 1'b0;
        div <= blink_div;
      end else if (&presc) begin
        div <= (div == 8'h00) ? blink_div : div - 8'd1;
        blink_q <= (div == 8'h00) ? ~blink_q : blink_q;
      end
      o_led <= ctrl[1] ? blink_q : ctrl[0];
    end
  end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: table vectors, corner sequences and model-checked random frames for spi_reg_bank
module tb_spi_reg_bank;
`ifdef SPI_REG_BANK_ERR_CNT_EN
  localparam int FIRST = 5;
  localparam logic [7:0] R4 = 8'h01;
`else
  localparam int FIRST = 4;
  localparam logic [7:0] R4 = 8'h00;
`endif
  logic clk = 0, rst = 1, cs_n = 1, rx_valid = 0;
  logic [7:0] rx_data = 0, tx_data;
  logic busy, led, led_en;
  int nvec = 0, nerr = 0;
  logic [7:0] mdl [16];
  logic [7:0] fq [$];

  typedef struct packed {
    logic [2:0] n;
    logic [0:2][7:0] b;
    logic [0:2][7:0] e;
    logic cl;
    logic l;
  } vec_t;
  vec_t tbl [11];

  spi_reg_bank #(.PRESCALE_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_cs_n(cs_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_tx_data(tx_data), .o_busy(busy), .o_led(led), .o_led_en(led_en));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, e0, e1, e2, input logic cl, l);
    vec_t v;
    v.n = 3'(n);
    v.b = {b0, b1, b2};
    v.e = {e0, e1, e2};
    v.cl = cl;
    v.l = l;
    return v;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_valid = 1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic run_vec(input vec_t v);
    cs_n = 0;
    @(negedge clk);
    for (int i = 0; i < int'(v.n); i++) begin
      send(v.b[i]);
      chk("vec_tx", tx_data, v.e[i]);
      @(negedge clk);
    end
    cs_n = 1;
    @(negedge clk);
    chk("vec_end_tx", tx_data, 8'hA5);
    chk("vec_end_busy", busy, 0);
    @(negedge clk);
    if (v.cl) chk("vec_led", led, v.l);
  endtask

  function automatic logic [7:0] mrd(input int a);
    return a == 0 ? 8'hA5 : mdl[a];
  endfunction

  task automatic mwr(input int a, input logic [7:0] d);
    if (a == 1 || a == 2 || a >= FIRST) mdl[a] = d;
  endtask

  task automatic model_init();
    foreach (mdl[i]) mdl[i] = 8'h00;
    mdl[2] = 8'hFF;
  endtask

  task automatic do_frame(input bit sim);
    bit bad = 0, wr = 0, last;
    int a = 0, n = fq.size();
    logic [7:0] e;
    cs_n = 0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        bad = fq[0][6:4] != 3'd0;
        wr = fq[0][7];
        a = int'(fq[0][3:0]);
        e = bad ? 8'hEE : wr ? 8'h00 : mrd(a);
        if (bad && FIRST == 5 && mdl[4] != 8'hFF) mdl[4] = mdl[4] + 8'd1;
      end else if (bad) e = 8'hEE;
      else if (wr) begin
        mwr((a + i - 1) % 16, fq[i]);
        e = 8'h00;
      end else e = mrd((a + i) % 16);
      last = sim && i == n - 1;
      rx_valid = 1;
      rx_data = fq[i];
      if (last) cs_n = 1;
      @(negedge clk);
      rx_valid = 0;
      if (!last) begin
        chk("rnd_tx", tx_data, e);
        chk("rnd_busy", busy, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    if (!(sim && n > 0)) begin
      cs_n = 1;
      @(negedge clk);
    end
    if (n > 0) mdl[3] = mdl[3] + 8'd1;
    chk("rnd_end_tx", tx_data, 8'hA5);
    chk("rnd_end_busy", busy, 0);
    @(negedge clk);
    if (!mdl[1][1]) chk("rnd_led", led, mdl[1][0]);
  endtask

  task automatic wait_tog(output int cyc);
    logic p = led;
    cyc = 0;
    while (led == p && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int c;
    logic [7:0] cmd, d;
    tbl[0]  = mk(2, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 0, 0);
    tbl[1]  = mk(1, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0);
    tbl[2]  = mk(2, 8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1);
    tbl[3]  = mk(2, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
    tbl[4]  = mk(3, 8'h8F, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 0, 0);
    tbl[5]  = mk(3, 8'h0F, 8'h00, 8'h00, 8'h11, 8'hA5, 8'h00, 0, 0);
    tbl[6]  = mk(2, 8'h70, 8'h33, 8'h00, 8'hEE, 8'hEE, 8'h00, 1, 0);
    tbl[7]  = mk(2, 8'h03, 8'h00, 8'h00, 8'h07, R4, 8'h00, 0, 0);
    tbl[8]  = mk(3, 8'h85, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 0, 0);
    tbl[9]  = mk(3, 8'h05, 8'h00, 8'h00, 8'h5A, 8'hC3, 8'h00, 0, 0);
    tbl[10] = mk(2, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h0A, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_tx", tx_data, 8'hA5);
    chk("rst_busy", busy, 0);
    chk("led_en", led_en, 1);
    foreach (tbl[i]) run_vec(tbl[i]);
    run_vec(mk(2, 8'h82, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
    run_vec(mk(2, 8'h81, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
    wait_tog(c);
    if (c >= 200) chk("blink_start", c, 0);
    for (int k = 0; k < 2; k++) begin
      wait_tog(c);
      chk("blink_period", c, 48);
    end
    c = 0;
    while (led !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("blink_high", led, 1);
    cs_n = 0;
    @(negedge clk);
    send(8'h81);
    send(8'h00);
    @(negedge clk);
    chk("blink_off_led", led, 0);
    cs_n = 1;
    @(negedge clk);
    cs_n = 0;
    @(negedge clk);
    send(8'h81);
    send(8'h05);
    send(8'h55);
    rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_tx", tx_data, 8'hA5);
    chk("midrst_led", led, 0);
    @(negedge clk);
    rst = 0;
    cs_n = 1;
    @(negedge clk);
    model_init();
    fq = '{8'h01, 8'h00};
    do_frame(0);
    fq = {};
    do_frame(0);
    fq = '{8'h03};
    do_frame(0);
    fq = '{8'h8A, 8'h12, 8'h34};
    do_frame(1);
    fq = '{8'h0A, 8'h00};
    do_frame(0);
    for (int f = 0; f < 60; f++) begin
      fq = {};
      cmd = {1'($urandom), 3'b000, 4'($urandom)};
      if ($urandom_range(0, 3) == 0) cmd[6:4] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 5) != 0) fq.push_back(cmd);
      for (int k = 1; k < $urandom_range(1, 5) && fq.size() > 0; k++) begin
        d = 8'($urandom);
        if (cmd[7] && cmd[6:4] == 3'd0 && (int'(cmd[3:0]) + k - 1) % 16 == 1) d[1] = 1'b0;
        fq.push_back(d);
      end
      do_frame($urandom_range(0, 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
